dbus_master: RTL and testbench

//  Processor-side initiator for the data-memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).

---
 rtl/dbus_master.sv | 171 +++++++++++++++++
 tb/tb_dbus_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_master.sv
// Data-bus initiator: one load/store per request, waits for ACKD_n.
// Optional abort on a silent responder: define DBUS_TIMEOUT_EN.
module dbus_master #(
  parameter int BIT_WIDTH = 32
`ifdef DBUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 rsp_valid,
  output logic [BIT_WIDTH-1:0] rsp_rdata,
  output logic                 stall,
  output logic                 err_misalign,
`ifdef DBUS_TIMEOUT_EN
  output logic                 err_timeout,
`endif
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  input  logic                 ACKD_n,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  typedef enum logic {
    IDLE,
    BUS
  } state_t;

  state_t state_q, state_d;

  logic [BIT_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [BIT_WIDTH-1:0] wfmt;
  logic [BIT_WIDTH-1:0] ext;
  logic [BIT_WIDTH-1:0] rdata_q;
  logic [1:0]           size_q;
  logic                 write_q;
  logic                 signed_q;
  logic                 rsp_q;
  logic                 mis_q;
  logic                 tmo_q;
  logic                 tmo_hit;
  logic                 bus;
  logic                 accept;
  logic                 misalign;
  logic                 start;
  logic                 ack;

  assign bus      = (state_q == BUS);
  assign accept   = req_valid & req_ready;
  assign misalign = ((req_size == 2'b00) & (|req_addr[1:0]))
                  | ((req_size == 2'b01) & req_addr[0]);
  assign start    = accept & ~misalign;
  assign ack      = bus & ~ACKD_n;

  assign req_ready    = ~bus & ~rsp_q & ~mis_q & ~tmo_q;
  assign stall        = req_valid & ~(rsp_q | mis_q | tmo_q);
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign err_misalign = mis_q;

  assign MREQ  = bus;
  assign DAD   = bus ? addr_q : '0;
  assign WRITE = bus & write_q;
  assign SIZE  = bus ? size_q : 2'b00;
  assign DDT   = (bus & write_q) ? wdata_q : 'z;

`ifdef DBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q;

  assign err_timeout = tmo_q;
  assign tmo_hit = bus & ACKD_n
                 & (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Count BUS cycles spent waiting for the acknowledge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
    end else if (start) begin
      tmo_cnt_q <= '0;
    end else if (bus) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Store data is zero-padded to the access width
  always_comb begin
    wfmt = req_wdata;
    unique case (1'b1)
      (req_size == 2'b00): wfmt = req_wdata;
      (req_size == 2'b01): wfmt = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      default:             wfmt = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    endcase
  end

  // Load data extension from the bus lanes
  always_comb begin
    ext = DDT;
    unique case (1'b1)
      (size_q == 2'b00): ext = DDT;
      (size_q == 2'b01):
        ext = {{(BIT_WIDTH-16){signed_q & DDT[15]}}, DDT[15:0]};
      default:
        ext = {{(BIT_WIDTH-8){signed_q & DDT[7]}}, DDT[7:0]};
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: ack takes priority over timeout on the same edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = BUS;
      BUS:  if (ack | tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, response capture and one-cycle status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      rdata_q  <= '0;
      rsp_q    <= 1'b0;
      mis_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      rsp_q <= ack;
      mis_q <= accept & misalign;
      tmo_q <= tmo_hit & ~ack;
      if (start) begin
        addr_q   <= req_addr;
        wdata_q  <= wfmt;
        size_q   <= (req_size == 2'b11) ? 2'b10 : req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
      end
      if (ack & ~write_q) begin
        rdata_q <= ext;
      end
    end
  end

endmodule

// File: tb/tb_dbus_master.sv
// Bench for dbus_master: directed bus transactions with a
// response scoreboard. Define DBUS_TIMEOUT_EN for the abort case.
module tb_dbus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall;
  logic        err_misalign;
  logic        err_timeout;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  wire  [31:0] ddt;
  logic        tb_oe;
  logic [31:0] tb_ddt;

  assign ddt = tb_oe ? tb_ddt : 'z;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata;

`ifdef DBUS_TIMEOUT_EN
  dbus_master #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
`else
  assign err_timeout = 1'b0;
  dbus_master #(.BIT_WIDTH(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .stall(stall),
    .err_misalign(err_misalign),
`ifdef DBUS_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n), .DDT(ddt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop one expectation per completion pulse
  always @(negedge clk) begin
    if (rst && (rsp_valid || err_misalign || err_timeout)) begin
      exp_t e;
      int   k;
      k = rsp_valid ? 0 : (err_misalign ? 1 : 2);
      chk("pulse_stall", {31'b0, stall}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", k, 99);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", k, e.kind);
        if (k == 0 && e.kind == 0) chk("rsp_rdata", rsp_rdata, e.data);
      end
    end
  end

  task automatic start_req(input logic wr, input logic [1:0] sz,
                           input logic sg, input logic [31:0] a,
                           input logic [31:0] wd, input string nm);
    int n;
    @(negedge clk);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, {31'b0, req_ready}, 32'h1);
  endtask

  task automatic xact(input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int lat, input logic [31:0] exp_bus,
                      input logic [31:0] exp_rsp, input string nm);
    logic [1:0] bsz;
    bsz = (sz == 2'b11) ? 2'b10 : sz;
    start_req(wr, sz, sg, a, wd, nm);
    if (!wr) exp_rdata = exp_rsp;
    sb.push_back('{0, exp_rdata});
    @(posedge clk);
    #1;
    tb_oe  = ~wr;
    tb_ddt = rd;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk({nm, "_mreq"}, {31'b0, MREQ}, 32'h1);
      chk({nm, "_dad"}, DAD, a);
      chk({nm, "_write"}, {31'b0, WRITE}, {31'b0, wr});
      chk({nm, "_size"}, {30'b0, SIZE}, {30'b0, bsz});
      chk({nm, "_stall"}, {31'b0, stall}, 32'h1);
      chk({nm, "_ddt"}, ddt, wr ? exp_bus : rd);
      if (k == lat) ACKD_n = 1'b0;
      @(posedge clk);
    end
    #1;
    ACKD_n = 1'b1;
    tb_oe  = 1'b1;
    tb_ddt = 32'h0;
    @(negedge clk);
    chk({nm, "_mreq_off"}, {31'b0, MREQ}, 32'h0);
    chk({nm, "_ddt_off"}, ddt, 32'h0);
    req_valid = 1'b0;
    tb_oe     = 1'b0;
  endtask

  task automatic misaligned(input logic [1:0] sz,
                            input logic [31:0] a, input string nm);
    start_req(1'b0, sz, 1'b0, a, 32'h0, nm);
    sb.push_back('{1, 32'h0});
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_mreq"}, {31'b0, MREQ}, 32'h0);
    chk({nm, "_stall"}, {31'b0, stall}, 32'h0);
    req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_mreq2"}, {31'b0, MREQ}, 32'h0);
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    ACKD_n     = 1'b1;
    tb_oe      = 1'b0;
    tb_ddt     = 32'h0;
    exp_rdata  = 32'h0;
    #3;
    chk("rst_mreq", {31'b0, MREQ}, 32'h0);
    chk("rst_write", {31'b0, WRITE}, 32'h0);
    chk("rst_size", {30'b0, SIZE}, 32'h0);
    chk("rst_dad", DAD, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_misalign", {31'b0, err_misalign}, 32'h0);
    chk("rst_timeout", {31'b0, err_timeout}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // loads: word, byte signed/unsigned, half signed/unsigned
    xact(0, 2'b00, 0, 32'h0800_0010, 0, 32'h1122_3344, 1,
         0, 32'h1122_3344, "ld_word");
    xact(0, 2'b10, 1, 32'h0800_0013, 0, 32'h0000_0080, 1,
         0, 32'hFFFF_FF80, "ld_byte_s");
    xact(0, 2'b11, 0, 32'h0800_0011, 0, 32'h0000_0080, 2,
         0, 32'h0000_0080, "ld_byte_u");
    xact(0, 2'b01, 1, 32'h0800_0002, 0, 32'h1234_8001, 1,
         0, 32'hFFFF_8001, "ld_half_s");
    xact(0, 2'b01, 0, 32'h0800_0006, 0, 32'hABCD_8001, 2,
         0, 32'h0000_8001, "ld_half_u");

    // stores keep the previous load data on rsp_rdata
    xact(1, 2'b10, 0, 32'hF000_0000, 32'h1234_5641, 0, 2,
         32'h0000_0041, 0, "st_byte");
    xact(1, 2'b00, 0, 32'h0800_0020, 32'hCAFE_F00D, 0, 1,
         32'hCAFE_F00D, 0, "st_word");

    misaligned(2'b00, 32'h0800_0002, "mis_word");
    misaligned(2'b01, 32'h0800_0001, "mis_half");

    xact(1, 2'b01, 0, 32'h0800_0004, 32'hDEAD_BEEF, 0, 3,
         32'h0000_BEEF, 0, "st_half_l3");

    // same store, reset in its second bus cycle
    start_req(1, 2'b01, 0, 32'h0800_0004, 32'hDEAD_BEEF, "rst_run");
    @(posedge clk);
    @(negedge clk);
    chk("rst_run_mreq_c1", {31'b0, MREQ}, 32'h1);
    chk("rst_run_ddt_c1", ddt, 32'h0000_BEEF);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_run_mreq", {31'b0, MREQ}, 32'h0);
    chk("rst_run_rsp", {31'b0, rsp_valid}, 32'h0);
    tb_oe  = 1'b1;
    tb_ddt = 32'h0;
    #1;
    chk("rst_run_ddt", ddt, 32'h0);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b0;
    tb_oe     = 1'b0;
    exp_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_run_idle", {31'b0, MREQ}, 32'h0);

    xact(1, 2'b10, 0, 32'h0800_0008, 32'h0000_00AA, 0, 1,
         32'h0000_00AA, 0, "st_after_rst");
    xact(0, 2'b00, 0, 32'h0800_000C, 0, 32'h5566_7788, 3,
         0, 32'h5566_7788, "ld_after_rst");

`ifdef DBUS_TIMEOUT_EN
    start_req(0, 2'b00, 0, 32'h0800_0040, 0, "tmo");
    sb.push_back('{2, 32'h0});
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("tmo_mreq", {31'b0, MREQ}, 32'h1);
      @(posedge clk);
    end
    @(negedge clk);
    chk("tmo_mreq_off", {31'b0, MREQ}, 32'h0);
    chk("tmo_pulse", {31'b0, err_timeout}, 32'h1);
    req_valid = 1'b0;
    xact(0, 2'b00, 0, 32'h0800_0044, 0, 32'h0BAD_CAFE, 1,
         0, 32'h0BAD_CAFE, "after_tmo");
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
